// File: rtl/draw_fb_writer.sv
// Framebuffer write stage: clips the draw engine's pixel stream, forms y*WIDTH+x addresses,
// issues writes under fb_ready backpressure and pulses done once a request has fully drained.
module draw_fb_writer #(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int COLRW  = 4,
    parameter int ADDRW  = $clog2(WIDTH*HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    drawing,
    input  logic                    draw_done,
    input  logic        [COLRW-1:0] colr,
    output logic                    oe,
    output logic                    fb_we,
    output logic        [ADDRW-1:0] fb_addr,
    output logic        [COLRW-1:0] fb_colr,
    input  logic                    fb_ready,
    output logic                    busy,
    output logic                    done,
    output logic        [15:0]      clip_cnt
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic signed [CORDW-1:0] X_LIM = CORDW'(WIDTH);
    localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(HEIGHT);
    localparam logic signed [CORDW-1:0] ZERO  = '0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_q, state_d;

    logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
    // Tags mark pixels accepted during DRAIN; they belong to the following request.
    logic n1_q, n2_q, n3_q, n1_d, n2_d, n3_d;
    logic pend_q, pend_d;
    logic done_q, done_d;
    logic [15:0]      clip_q;
    logic [XW-1:0]    x1_q;
    logic [YW-1:0]    y1_q;
    logic [COLRW-1:0] c1_q, c2_q, c3_q;
    logic [ADDRW-1:0] a2_q, a3_q;
    logic advance, accept, in_bounds, old_clear, fire;

    assign advance   = !(v3_q && !fb_ready);
    assign accept    = drawing && advance;
    assign in_bounds = (x >= ZERO) && (x < X_LIM) && (y >= ZERO) && (y < Y_LIM);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        n1_d = n1_q;
        n2_d = n2_q;
        n3_d = n3_q;
        if (advance) begin
            v1_d = accept && in_bounds;
            v2_d = v1_q;
            v3_d = v2_q;
            n1_d = (state_q == DRAIN);
            n2_d = n1_q;
            n3_d = n2_q;
        end
        // True when no pixel of the current request remains after this edge.
        old_clear = !(v1_d && !n1_d) && !(v2_d && !n2_d) && !(v3_d && !n3_d);
        pend_d    = pend_q || (accept && (state_q == DRAIN));
        fire      = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (draw_done) begin
                    if (old_clear) fire = 1'b1;
                    else           state_d = DRAIN;
                end else if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (draw_done) begin
                    if (old_clear) fire = 1'b1;
                    else           state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (old_clear) fire = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (fire) begin
            state_d = pend_d ? RUN : IDLE;
            pend_d  = 1'b0;
            n1_d    = 1'b0;
            n2_d    = 1'b0;
            n3_d    = 1'b0;
        end
        done_d = fire;
    end

    // NOTE: state is updated with non-blocking assignments only; the datapath registers are
    // reset as well so fb_addr/fb_colr come out of reset at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            {v1_q, v2_q, v3_q} <= '0;
            {n1_q, n2_q, n3_q} <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            clip_q  <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
        end else begin
            state_q <= state_d;
            {v1_q, v2_q, v3_q} <= {v1_d, v2_d, v3_d};
            {n1_q, n2_q, n3_q} <= {n1_d, n2_d, n3_d};
            pend_q  <= pend_d;
            done_q  <= done_d;
            if (accept && !in_bounds && (clip_q != 16'hFFFF)) clip_q <= clip_q + 16'd1;
            if (advance) begin
                x1_q <= x[XW-1:0];
                y1_q <= y[YW-1:0];
                c1_q <= colr;
                a2_q <= ADDRW'(y1_q) * ADDRW'(WIDTH) + ADDRW'(x1_q);
                c2_q <= c1_q;
                a3_q <= a2_q;
                c3_q <= c2_q;
            end
        end
    end

    assign oe       = advance;
    assign fb_we    = v3_q;
    assign fb_addr  = a3_q;
    assign fb_colr  = c3_q;
    assign done     = done_q;
    assign clip_cnt = clip_q;
    assign busy     = (state_q != IDLE) || v1_q || v2_q || v3_q;
endmodule

// File: tb/tb_draw_fb_writer.sv
// Self-checking bench for draw_fb_writer: vector table, hand-written corner sequences and
// randomized requests scored against an address/colour queue model.
`timescale 1ns/1ps
module tb_draw_fb_writer;
    localparam int CORDW = 16, WIDTH = 160, HEIGHT = 120, COLRW = 4, ADDRW = 15;

    logic clk = 1'b0;
    logic rst;
    logic signed [CORDW-1:0] x, y;
    logic drawing, draw_done, fb_ready;
    logic [COLRW-1:0] colr, fb_colr;
    logic oe, fb_we, busy, done;
    logic [ADDRW-1:0] fb_addr;
    logic [15:0] clip_cnt;

    always #5 clk = ~clk;

    draw_fb_writer #(.CORDW(CORDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLRW(COLRW), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .drawing(drawing), .draw_done(draw_done), .colr(colr),
        .oe(oe), .fb_we(fb_we), .fb_addr(fb_addr), .fb_colr(fb_colr), .fb_ready(fb_ready),
        .busy(busy), .done(done), .clip_cnt(clip_cnt)
    );

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every accepted in-screen pixel owes exactly one write, in order.
    typedef struct { int addr; int colr; } wr_t;
    wr_t exp_q[$];
    wr_t e;
    int  model_clip;
    bit  dd_pend, prev_stall;
    int  prev_addr, prev_colr;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_clip = 0;
            dd_pend    = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_we", fb_we, 1);
                check("hold_addr", fb_addr, prev_addr);
                check("hold_colr", fb_colr, prev_colr);
            end
            check("oe", oe, !(fb_we && !fb_ready));
            if (done) begin
                check("done_requested", dd_pend, 1);
                check("done_drained", exp_q.size(), 0);
                dd_pend = 0;
            end
            if (drawing && oe) begin
                if (x >= 0 && x < WIDTH && y >= 0 && y < HEIGHT)
                    exp_q.push_back('{int'(y) * WIDTH + int'(x), int'(colr)});
                else if (model_clip < 65535)
                    model_clip++;
            end
            if (fb_we && fb_ready) begin
                if (exp_q.size() == 0) check("spurious_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("wr_addr", fb_addr, e.addr);
                    check("wr_colr", fb_colr, e.colr);
                end
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr  = int'(fb_addr);
            prev_colr  = int'(fb_colr);
        end
    end

    // Per-sequence log of what happened in each cycle, indexed from the first driven cycle.
    int log_we[$], log_addr[$], log_colr[$], log_done[$];
    int n_oe_low, cyc_idx;

    task automatic clear_log();
        log_we.delete(); log_addr.delete(); log_colr.delete(); log_done.delete();
        n_oe_low = 0;
        cyc_idx  = 0;
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cyc(input bit d, input int px, input int py, input int c, input bit dd, input bit rdy);
        drawing = d; x = px[CORDW-1:0]; y = py[CORDW-1:0]; colr = c[COLRW-1:0];
        draw_done = dd; fb_ready = rdy;
        if (dd) dd_pend = 1;
        @(negedge clk);
        if (fb_we && fb_ready) begin
            log_we.push_back(cyc_idx); log_addr.push_back(int'(fb_addr)); log_colr.push_back(int'(fb_colr));
        end
        if (done) log_done.push_back(cyc_idx);
        if (!oe) n_oe_low++;
        cyc_idx++;
        tick();
    endtask

    typedef struct { int px; int py; int c; bit exp_we; int exp_addr; } vec_t;
    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, guard;
        bit  accepted, dd_sent, got;

        vecs[0]  = '{10, 5, 3, 1, 810};
        vecs[1]  = '{0, 0, 7, 1, 0};
        vecs[2]  = '{159, 119, 15, 1, 19199};
        vecs[3]  = '{-1, 0, 1, 0, 0};
        vecs[4]  = '{160, 0, 2, 0, 0};
        vecs[5]  = '{0, 120, 4, 0, 0};
        vecs[6]  = '{0, -5, 5, 0, 0};
        vecs[7]  = '{159, 0, 9, 1, 159};
        vecs[8]  = '{0, 119, 6, 1, 19040};
        vecs[9]  = '{-32768, 32767, 8, 0, 0};
        vecs[10] = '{100, 60, 10, 1, 9700};

        rst = 1; x = 0; y = 0; drawing = 0; draw_done = 0; colr = 0; fb_ready = 1;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        check("rst_fb_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oe", oe, 1);
        check("rst_clip", clip_cnt, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_colr", fb_colr, 0);
        tick();

        // Clipping: three off-screen pixels and one corner pixel.
        clear_log();
        cyc(1, -1, 0, 5, 0, 1);
        cyc(1, 160, 0, 5, 0, 1);
        cyc(1, 0, 120, 5, 0, 1);
        cyc(1, 159, 119, 5, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        repeat (6) cyc(0, 0, 0, 0, 0, 1);
        check("clip_writes", log_we.size(), 1);
        check("clip_we_cycle", first_of(log_we), 6);
        check("clip_addr", first_of(log_addr), 19199);
        check("clip_done_cycle", first_of(log_done), 7);
        check("clip_done_count", log_done.size(), 1);
        check("clip_cnt", clip_cnt, 3);
        check("clip_busy", busy, 0);

        // Single pixels from the vector table, draw_done the cycle after each.
        for (int i = 0; i < 11; i++) begin
            clear_log();
            cyc(1, vecs[i].px, vecs[i].py, vecs[i].c, 0, 1);
            cyc(0, 0, 0, 0, 1, 1);
            repeat (8) cyc(0, 0, 0, 0, 0, 1);
            if (vecs[i].exp_we) begin
                check("vec_we_count", log_we.size(), 1);
                check("vec_we_cycle", first_of(log_we), 3);
                check("vec_addr", first_of(log_addr), vecs[i].exp_addr);
                check("vec_colr", first_of(log_colr), vecs[i].c);
                check("vec_done_cycle", first_of(log_done), 4);
            end else begin
                check("vec_no_write", log_we.size(), 0);
                check("vec_done_cycle", first_of(log_done), 2);
            end
            check("vec_done_count", log_done.size(), 1);
            check("vec_busy", busy, 0);
        end
        check("vec_clip_total", clip_cnt, 8);

        // Burst of four on the bottom row: back-to-back writes, no stall.
        clear_log();
        for (int i = 0; i < 4; i++) cyc(1, i, 119, i + 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        repeat (6) cyc(0, 0, 0, 0, 0, 1);
        check("burst_writes", log_we.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("burst_cycle", (log_we.size() > i) ? log_we[i] : -1, 3 + i);
            check("burst_addr", (log_addr.size() > i) ? log_addr[i] : -1, 19040 + i);
        end
        check("burst_oe_low", n_oe_low, 0);
        check("burst_done_cycle", first_of(log_done), 7);

        // Backpressure: fb_ready low for five cycles once fb_we rises.
        clear_log();
        for (int i = 0; i < 3; i++) cyc(1, 20 + i, 30, i + 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 0, 1);
        check("bp_oe_low", n_oe_low, 5);
        check("bp_writes", log_we.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("bp_cycle", (log_we.size() > i) ? log_we[i] : -1, 8 + i);
            check("bp_addr", (log_addr.size() > i) ? log_addr[i] : -1, 4820 + i);
        end
        check("bp_done_cycle", first_of(log_done), 11);
        check("bp_done_count", log_done.size(), 1);

        // Reset with two pixels in flight: nothing written, no done, counters cleared.
        clear_log();
        cyc(1, 5, 5, 1, 0, 1);
        cyc(1, 6, 5, 1, 0, 1);
        check("rstmid_busy_before", busy, 1);
        rst = 1;
        cyc(0, 0, 0, 0, 0, 1);
        rst = 0;
        check("rstmid_fb_we", fb_we, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_clip", clip_cnt, 0);
        repeat (8) cyc(0, 0, 0, 0, 0, 1);
        check("rstmid_no_write", log_we.size(), 0);
        check("rstmid_no_done", log_done.size(), 0);

        // Randomized requests with bubbles, clipping and random fb_ready.
        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, 12);
            dd_sent = 0;
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drawing = 0; fb_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                x = CORDW'(int'($urandom_range(0, 199)) - 20);
                y = CORDW'(int'($urandom_range(0, 159)) - 20);
                colr = COLRW'($urandom);
                drawing = 1;
                accepted = 0;
                guard = 0;
                while (!accepted && guard < 100) begin
                    fb_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (oe) begin
                        accepted = 1;
                        if (p == n - 1 && $urandom_range(0, 1) == 1) begin
                            #1;
                            draw_done = 1; dd_pend = 1; dd_sent = 1;
                        end
                    end
                    tick();
                    draw_done = 0;
                    guard++;
                end
                if (!accepted) check("rand_accept_timeout", 0, 1);
            end
            drawing = 0;
            if (!dd_sent) begin
                draw_done = 1; dd_pend = 1;
                tick();
                draw_done = 0;
            end
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                fb_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (done) begin
                    got = 1;
                    check("rand_busy", busy, 0);
                end
                tick();
            end
            check("rand_done", got, 1);
            check("rand_clip", clip_cnt, model_clip);
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_fb_writer.md
Name: draw_fb_writer

Overview:
- Downstream stage of the quad/line drawing engines: consumes the pixel stream (x, y, drawing) and turns it into framebuffer write transactions.
- Clips pixels to the screen, computes the linear framebuffer address, attaches the draw colour, and applies memory backpressure to the draw engine through oe.
- Produces a single-cycle done once the drawing request has completed and every accepted pixel has been written.

Parameters:
- CORDW, 16, signed coordinate width of x/y.
- WIDTH, 160, framebuffer width in pixels.
- HEIGHT, 120, framebuffer height in pixels.
- COLRW, 4, colour width.
- ADDRW, $clog2(WIDTH*HEIGHT), framebuffer address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- x  in  CORDW signed  pixel x from draw engine
- y  in  CORDW signed  pixel y from draw engine
- drawing  in  1  x/y hold a valid pixel this cycle
- draw_done  in  1  draw engine finished (one-cycle pulse)
- colr  in  COLRW  colour for the current shape, sampled with each pixel
- oe  out  1  output enable to draw engine; pixel advances only when high
- fb_we  out  1  framebuffer write valid
- fb_addr  out  ADDRW  write address, y*WIDTH+x
- fb_colr  out  COLRW  write data
- fb_ready  in  1  framebuffer accepts the write this cycle
- busy  out  1  pixels in flight or done pending
- done  out  1  all writes for the request complete (one-cycle pulse)
- clip_cnt  out  16  pixels discarded by clipping since reset (saturating)

Behaviour:
- Pipeline: 3 stages. S1 = clip/register, S2 = address multiply, S3 = output register driving fb_we/fb_addr/fb_colr. Each stage has a valid bit.
- advance = !(fb_we && !fb_ready). All stages shift together when advance=1 and hold when advance=0.
- oe = advance. This is combinational from fb_ready; the path is accepted.
- Input is accepted when drawing && oe.
- S1 valid = accepted && 0<=x<WIDTH && 0<=y<HEIGHT, using a signed compare.
- An accepted pixel that is out of bounds is dropped and increments clip_cnt by 1, saturating at 16'hFFFF.
- S1 stores x, y (truncated to in-range width) and colr.
- S2 computes addr = y*WIDTH + x as an unsigned result of ADDRW bits. No overflow is possible for in-bounds pixels.
- Latency from acceptance to fb_we is 3 cycles with fb_ready held high.
- Write handshake: a write completes on a cycle where fb_we && fb_ready. fb_addr and fb_colr stay stable while fb_we=1 && fb_ready=0.
- fb_we must not drop without a completed handshake.
- Throughput: 1 pixel/cycle with fb_ready=1. Bubbles (drawing=0 or clipped pixels) propagate as invalid slots.
- Done tracking, state machine with states IDLE, RUN, DRAIN:
  - IDLE -> RUN on the first accepted pixel (drawing && oe).
  - RUN -> DRAIN on draw_done.
  - DRAIN -> IDLE when all stage valids are 0 after an advance. done=1 for exactly that one cycle.
  - draw_done in IDLE (all pixels clipped, or an empty shape) -> done pulse the next cycle, state stays IDLE.
  - draw_done in the same cycle as the last accepted pixel: that pixel is still written before done.
- busy = (state != IDLE) || any stage valid.
- Back-to-back requests: a pixel accepted while in DRAIN belongs to the next request. Go to RUN after the done pulse, keeping in-flight pixels. The pulse occurs only when the earlier pixels have drained, i.e. the valids ahead of the new pixel are clear.
- Simplification: the draw engine never issues a new start before done. The bench does not overlap requests.
- Reset values: fb_we=0, all valids=0, done=0, busy=0, state=IDLE, clip_cnt=0, oe=1 (no stall). fb_addr and fb_colr reset to 0.
- Reset mid-operation discards all in-flight pixels with no write and no done.
- fb_ready is ignored when fb_we=0.

Test Plan:
- Single pixel (10,5), colr=3, fb_ready=1 -> fb_we high 3 cycles after acceptance, fb_addr=810, fb_colr=3. With draw_done the next cycle, done pulses once after the write; busy then 0.
- Burst of 4 pixels x=0..3, y=119 on consecutive cycles -> 4 consecutive writes at addr 19040..19043, no gaps, oe constant 1.
- Clipping: pixels (-1,0), (160,0), (0,120), (159,119) -> one write at addr 19199, clip_cnt=3; then draw_done -> done.
- Backpressure: 3-pixel burst with fb_ready=0 for 5 cycles once fb_we rises -> oe=0 during the stall, fb_addr/fb_colr stable, no pixel lost or duplicated, 3 writes total.
- All pixels clipped, then draw_done -> done pulse the cycle after draw_done, no fb_we ever.
- rst asserted with 2 pixels in flight -> fb_we=0, busy=0 next cycle, no done; clip_cnt cleared.
